// File: rtl/switch_pkg.sv
// Shared types for the per-core Switch port adapter.
// Lanes carry IEEE-754 single-precision bit patterns so the datapath stays synthesizable.
package switch_pkg;

  typedef logic [31:0] lane_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT
  } recv_state_t;

  function automatic logic core_idx_legal(input int unsigned idx, input int unsigned self,
                                          input int unsigned size);
    return (idx != self) && (idx < size);
  endfunction

endpackage

// File: rtl/switch_port_fifo.sv
// Outbound message FIFO: registered head, count-based full/empty.
module switch_port_fifo
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH          = 2,
  parameter int unsigned CORE_ADDR_SIZE = 2,
  parameter int unsigned SEND_DEPTH     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [CORE_ADDR_SIZE-1:0] push_idx,
  input  lane_t                     push_data [WIDTH],
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [CORE_ADDR_SIZE-1:0] head_idx,
  output lane_t                     head_data [WIDTH]
);

  localparam int unsigned PTR_W = $clog2(SEND_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = SEND_DEPTH[PTR_W:0];

  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]            count_q;
  logic [CORE_ADDR_SIZE-1:0] mem_idx  [SEND_DEPTH];
  lane_t                     mem_data [SEND_DEPTH][WIDTH];
  logic                      do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_idx[wr_ptr_q] <= push_idx;
      for (int i = 0; i < int'(WIDTH); i++) mem_data[wr_ptr_q][i] <= push_data[i];
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  always_comb begin
    head_idx = empty ? '0 : mem_idx[rd_ptr_q];
    for (int i = 0; i < int'(WIDTH); i++) head_data[i] = empty ? '0 : mem_data[rd_ptr_q][i];
  end

endmodule

// File: rtl/switch_port.sv
// Per-core adapter to one Switch port: buffered outbound sends and a one-shot receive FSM.
module switch_port
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH          = 2,
  parameter int unsigned CORE_SIZE      = 3,
  parameter int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE),
  parameter int unsigned CORE_IDX       = 0,
  parameter int unsigned SEND_DEPTH     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      core_send_valid,
  input  logic [CORE_ADDR_SIZE-1:0] core_send_dst,
  input  lane_t                     core_send_data [WIDTH],
  output logic                      core_send_full,
  input  logic                      core_recv_valid,
  input  logic [CORE_ADDR_SIZE-1:0] core_recv_src,
  output logic                      core_recv_busy,
  output logic                      core_recv_done,
  output lane_t                     core_recv_data [WIDTH],
  output logic                      core_err,
  output logic                      send_ready,
  output logic [CORE_ADDR_SIZE-1:0] send_core_idx,
  output lane_t                     send_data [WIDTH],
  input  logic                      send_ok,
  output logic                      recv_request,
  output logic [CORE_ADDR_SIZE-1:0] recv_core_idx,
  input  logic                      recv_ready,
  input  lane_t                     recv_data [WIDTH]
);

  logic send_dst_ok, recv_src_ok, fifo_push, fifo_empty, send_err, recv_err, capture;
  recv_state_t state_q, state_d;
  logic [CORE_ADDR_SIZE-1:0] src_q, src_d;
  logic done_q, err_q;
  lane_t rdata_q [WIDTH];

  assign send_dst_ok = core_idx_legal(32'(core_send_dst), CORE_IDX, CORE_SIZE);
  assign recv_src_ok = core_idx_legal(32'(core_recv_src), CORE_IDX, CORE_SIZE);
  assign fifo_push   = core_send_valid && send_dst_ok;
  // When full the FIFO is non-empty, so send_ok alone decides whether a slot frees up.
  assign send_err    = core_send_valid && (!send_dst_ok || (core_send_full && !send_ok));

  switch_port_fifo #(
    .WIDTH          (WIDTH),
    .CORE_ADDR_SIZE (CORE_ADDR_SIZE),
    .SEND_DEPTH     (SEND_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_idx  (core_send_dst),
    .push_data (core_send_data),
    .pop       (send_ok),
    .full      (core_send_full),
    .empty     (fifo_empty),
    .head_idx  (send_core_idx),
    .head_data (send_data)
  );

  assign send_ready = !fifo_empty;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    capture  = 1'b0;
    recv_err = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (core_recv_valid) begin
          if (recv_src_ok) begin
            state_d = R_REQ;
            src_d   = core_recv_src;
          end else begin
            recv_err = 1'b1;
          end
        end
      end
      R_REQ: begin
        if (recv_ready) begin
          capture = 1'b1;
          state_d = R_IDLE;
        end else begin
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (recv_ready) begin
          capture = 1'b1;
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= R_IDLE;
      src_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      done_q  <= capture;
      err_q   <= err_q | send_err | recv_err;
      if (capture) begin
        for (int i = 0; i < int'(WIDTH); i++) rdata_q[i] <= recv_data[i];
      end
    end
  end

  assign recv_request   = (state_q == R_REQ);
  assign recv_core_idx  = src_q;
  assign core_recv_busy = (state_q != R_IDLE);
  assign core_recv_done = done_q;
  assign core_recv_data = rdata_q;
  assign core_err       = err_q;

endmodule
